// File: rtl/nx1_vfetch.sv
// nx1_vfetch -- VRAM line fetch stage for the X1 video path.
// Issues MCB-style read bursts against the ABRG plane words in DRAM and
// fills one scanline into a ping-pong line buffer. The pixel serializer
// reads that buffer on the same clock with one cycle of latency.
// Optional feature: define NX1_VFETCH_TIMEOUT_EN to add a read-data
// timeout that zero-fills the rest of the line and flags an error.
module nx1_vfetch #(
  parameter logic [31:0] def_VBASE    = 32'h0018_0000,
  parameter int          def_BL       = 16,
  parameter int          def_LINE_MAX = 128
) (
  input  logic        mem_clk,
  input  logic        mem_rst,
  input  logic        mem_init_done,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_empty,
  input  logic        mem_rd_overflow,
  input  logic        mem_rd_error,
  input  logic        v_line_req,
  input  logic [13:0] v_line_addr,
  input  logic [7:0]  v_line_words,
  input  logic        v_page,
  input  logic        v_bank,
  output logic        v_busy,
  output logic        v_line_done,
  output logic        v_err,
  input  logic        v_err_clr,
  input  logic        v_rd_bank,
  input  logic [6:0]  v_rd_addr,
  output logic [31:0] v_rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE,
    ST_ZFILL
  } state_e;

  state_e      state_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        err_d;
  logic        page_q;
  logic        bank_q;
  logic [13:0] cur_addr_q;
  logic [7:0]  rem_q;
  logic [6:0]  widx_q;
  logic [7:0]  burst_left_q;
  logic [31:0] rd_data_q;

  logic        req_accept;
  logic        words_over;
  logic [7:0]  words_eff;
  logic [7:0]  len_bl;
  logic [14:0] len_wrap;
  logic [7:0]  burst_len;
  logic        timeout;
  logic        err_set;

  logic        buf_we;
  logic [7:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic [31:0] line_mem [0:2*def_LINE_MAX-1];

  // Request acceptance and word-count clamp to the line buffer depth.
  assign req_accept = (state_q == ST_IDLE) & v_line_req & mem_init_done;
  assign words_over = v_line_words > 8'(def_LINE_MAX);
  assign words_eff  = words_over ? 8'(def_LINE_MAX) : v_line_words;

  // Burst length: remaining words, capped by the burst limit and by the
  // distance to the 14-bit VRAM wrap so no burst straddles address 0.
  assign len_bl    = (rem_q > 8'(def_BL)) ? 8'(def_BL) : rem_q;
  assign len_wrap  = 15'd16384 - {1'b0, cur_addr_q};
  assign burst_len = ({7'd0, len_bl} > len_wrap) ? len_wrap[7:0] : len_bl;

  // NOTE: the FIFO handshakes are combinational so that en and full/empty
  // refer to the same clock edge; a registered en would act on stale status.
  assign mem_cmd_en        = (state_q == ST_CMD) & ~mem_cmd_full;
  assign mem_cmd_instr     = 3'b001;
  assign mem_cmd_bl        = (state_q == ST_CMD) ? 6'(burst_len - 8'd1) : 6'd0;
  assign mem_cmd_byte_addr = (state_q == ST_CMD)
                           ? def_VBASE[29:0] + {13'd0, page_q, cur_addr_q, 2'b00}
                           : 30'd0;
  assign mem_rd_en         = (state_q == ST_DATA) & ~mem_rd_empty;

`ifdef NX1_VFETCH_TIMEOUT_EN
  logic [7:0] to_cnt_q;

  // Read-data watchdog: counts empty cycles in DATA, restarts on every beat.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      to_cnt_q <= 8'd0;
    end else if ((state_q != ST_DATA) || mem_rd_en) begin
      to_cnt_q <= 8'd0;
    end else if (to_cnt_q != 8'hFF) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign timeout = (state_q == ST_DATA) & ~mem_rd_en & (to_cnt_q == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  // Fetch sequencer: IDLE -> CMD -> DATA (-> CMD ...) -> DONE -> IDLE.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      page_q       <= 1'b0;
      bank_q       <= 1'b0;
      cur_addr_q   <= 14'd0;
      rem_q        <= 8'd0;
      widx_q       <= 7'd0;
      burst_left_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_accept) begin
            page_q     <= v_page;
            bank_q     <= v_bank;
            cur_addr_q <= v_line_addr;
            rem_q      <= words_eff;
            widx_q     <= 7'd0;
            busy_q     <= 1'b1;
            state_q    <= (words_eff == 8'd0) ? ST_DONE : ST_CMD;
          end
        end
        ST_CMD: begin
          if (!mem_cmd_full) begin
            burst_left_q <= burst_len;
            state_q      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_rd_en) begin
            widx_q       <= widx_q + 7'd1;
            cur_addr_q   <= cur_addr_q + 14'd1;
            rem_q        <= rem_q - 8'd1;
            burst_left_q <= burst_left_q - 8'd1;
            if (burst_left_q == 8'd1) begin
              state_q <= (rem_q == 8'd1) ? ST_DONE : ST_CMD;
            end
          end else if (timeout) begin
            state_q <= ST_ZFILL;
          end
        end
        ST_ZFILL: begin
          widx_q <= widx_q + 7'd1;
          rem_q  <= rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky error: a set in the same cycle as a clear wins.
  assign err_set = mem_rd_overflow | mem_rd_error | (req_accept & words_over) | timeout;

  always_comb begin
    err_d = err_q;
    if (v_err_clr) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  // Buffer write source: popped FIFO beats, or zeros while filling a timed-out line.
  always_comb begin
    buf_we    = mem_rd_en;
    buf_wdata = mem_rd_data;
    if (state_q == ST_ZFILL) begin
      buf_we    = 1'b1;
      buf_wdata = 32'd0;
    end
  end

  assign buf_waddr = {bank_q, widx_q};

  // NOTE: the line buffer array carries no reset so it maps onto block RAM;
  // its contents are undefined until a fetch writes them.
  always_ff @(posedge mem_clk) begin
    if (buf_we) line_mem[buf_waddr] <= buf_wdata;
  end

  // Registered read port; a same-cycle write to the same word returns old data.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) rd_data_q <= 32'd0;
    else         rd_data_q <= line_mem[{v_rd_bank, v_rd_addr}];
  end

  assign v_busy      = busy_q;
  assign v_line_done = done_q;
  assign v_err       = err_q;
  assign v_rd_data   = rd_data_q;

endmodule
